// File: rtl/bu_pkg.sv
// Shared types, modulus constants and modular helpers for the butterfly array.
// Helpers work on 64-bit words so callers of any narrower width can reuse them.
package bu_pkg;

  typedef enum logic {BU_CT = 1'b0, BU_GS = 1'b1} bu_mode_e;

  typedef logic [63:0] bu_word_t;

  localparam int unsigned Q_DEFAULT = 8380417;
  localparam int unsigned BARRETT_K = 2 * $clog2(Q_DEFAULT);
  localparam bu_word_t    BARRETT_M = (bu_word_t'(1) << BARRETT_K) / bu_word_t'(Q_DEFAULT);

  function automatic bu_word_t mod_add(input bu_word_t a, input bu_word_t b, input bu_word_t q);
    bu_word_t s;
    s = a + b;
    return (s >= q) ? s - q : s;
  endfunction

  function automatic bu_word_t mod_sub(input bu_word_t a, input bu_word_t b, input bu_word_t q);
    return (a >= b) ? a - b : a + q - b;
  endfunction

  // Division by two in the field: odd values borrow one Q to become even.
  function automatic bu_word_t mod_half(input bu_word_t x, input bu_word_t q);
    return x[0] ? (x + q) >> 1 : x >> 1;
  endfunction

endpackage

// File: rtl/bu_pipe_array_mul.sv
// Two-stage modular multiplier: registered full product, then registered
// Barrett reduction. Both stages advance only when en_i is high.
module mod_mul_barrett
  import bu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned Q          = Q_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] p_o
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned XW = PW + 64;
  localparam int unsigned K  = (Q == Q_DEFAULT) ? BARRETT_K : 2 * $clog2(Q);
  localparam bu_word_t    M  = (Q == Q_DEFAULT) ? BARRETT_M
                                                : (bu_word_t'(1) << K) / bu_word_t'(Q);

  logic [PW-1:0] prod_q;
  logic [PW-1:0] q_est;
  logic [PW-1:0] r0;
  logic [PW-1:0] r1;

  // Product is below 2^K, so the quotient estimate is short by at most two.
  always_comb begin
    q_est = PW'((XW'(prod_q) * XW'(M)) >> K);
    r0    = prod_q - q_est * PW'(Q);
    r1    = (r0 >= PW'(Q)) ? r0 - PW'(Q) : r0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      prod_q <= '0;
      p_o    <= '0;
    end else if (en_i) begin
      prod_q <= PW'(a_i) * PW'(b_i);
      p_o    <= DATA_WIDTH'((r1 >= PW'(Q)) ? r1 - PW'(Q) : r1);
    end
  end

endmodule

// File: rtl/bu_pipe_array.sv
// Multi-lane CT/GS modular butterfly, three stages with a global stall.
// S1 multiply / GS add-sub, S2 Barrett reduce, S3 CT add-sub and halving.
module bu_pipe_array
  import bu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 2,
  parameter int unsigned Q          = Q_DEFAULT,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        mode_i,
  input  logic                        half_i,
  input  logic [TAG_WIDTH-1:0]        tag_i,
  input  logic [LANES*DATA_WIDTH-1:0] a_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_i,
  input  logic [LANES*DATA_WIDTH-1:0] zeta_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [TAG_WIDTH-1:0]        tag_o,
  output logic [LANES*DATA_WIDTH-1:0] a_o,
  output logic [LANES*DATA_WIDTH-1:0] b_o,
  output logic                        busy_o
);

  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam bu_word_t Q_W = bu_word_t'(Q);

  logic                                adv;
  logic                                v1, v2;
  bu_mode_e                            m1, m2;
  logic                                h1, h2;
  logic [TAG_WIDTH-1:0]                t1, t2;
  logic [LANES-1:0][DATA_WIDTH-1:0]    s1_a_d, s1_a, s2_a, s2_t;
  logic [LANES-1:0][DATA_WIDTH-1:0]    res_a_d, res_b_d, res_a, res_b;

  // One stall signal for every stage keeps beats in lock-step with no bubble squeeze.
  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = adv;
  assign busy_o     = v1 || v2 || out_valid_o;
  assign a_o        = res_a;
  assign b_o        = res_b;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    word_t a_l, b_l, z_l, mul_x, s1_d, ra, rb;

    assign a_l = a_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign b_l = b_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign z_l = zeta_i[k*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
      mul_x = b_l;
      s1_d  = a_l;
      if (mode_i == BU_GS) begin
        mul_x = word_t'(mod_sub(bu_word_t'(a_l), bu_word_t'(b_l), Q_W));
        s1_d  = word_t'(mod_add(bu_word_t'(a_l), bu_word_t'(b_l), Q_W));
      end
    end

    assign s1_a_d[k] = s1_d;

    mod_mul_barrett #(
      .DATA_WIDTH(DATA_WIDTH),
      .Q         (Q)
    ) u_mul (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .en_i    (adv),
      .a_i     (mul_x),
      .b_i     (z_l),
      .p_o     (s2_t[k])
    );

    always_comb begin
      ra = s2_a[k];
      rb = s2_t[k];
      if (m2 == BU_CT) begin
        ra = word_t'(mod_add(bu_word_t'(s2_a[k]), bu_word_t'(s2_t[k]), Q_W));
        rb = word_t'(mod_sub(bu_word_t'(s2_a[k]), bu_word_t'(s2_t[k]), Q_W));
      end
      if (h2) begin
        ra = word_t'(mod_half(bu_word_t'(ra), Q_W));
        rb = word_t'(mod_half(bu_word_t'(rb), Q_W));
      end
    end

    assign res_a_d[k] = ra;
    assign res_b_d[k] = rb;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid_o <= 1'b0;
      m1          <= BU_CT;
      m2          <= BU_CT;
      h1          <= 1'b0;
      h2          <= 1'b0;
      t1          <= '0;
      t2          <= '0;
      tag_o       <= '0;
      s1_a        <= '0;
      s2_a        <= '0;
      res_a       <= '0;
      res_b       <= '0;
    end else if (adv) begin
      v1          <= in_valid_i;
      m1          <= bu_mode_e'(mode_i);
      h1          <= half_i;
      t1          <= tag_i;
      s1_a        <= s1_a_d;
      v2          <= v1;
      m2          <= m1;
      h2          <= h1;
      t2          <= t1;
      s2_a        <= s1_a;
      out_valid_o <= v2;
      tag_o       <= t2;
      res_a       <= res_a_d;
      res_b       <= res_b_d;
    end
  end

endmodule

// File: tb/tb_bu_pipe_array.sv
// Directed-vector and streaming bench for bu_pipe_array (LANES=2, Q=8380417).
module tb_bu_pipe_array;
  import bu_pkg::*;

  localparam int DW = 32;
  localparam int LN = 2;
  localparam int TW = 8;
  localparam longint unsigned QQ = 64'd8380417;
  localparam logic [31:0] QM1 = 32'd8380416;
  localparam logic [31:0] QM2 = 32'd8380415;
  localparam logic [31:0] QM3 = 32'd8380414;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  logic in_valid = 1'b0, in_ready, mode = 1'b0, half = 1'b0;
  logic out_valid, out_ready = 1'b1, busy;
  logic [TW-1:0] tag_in = '0, tag_out;
  logic [LN*DW-1:0] a_in = '0, b_in = '0, z_in = '0, a_out, b_out;

  int n_checks = 0;
  int n_fail = 0;

  bu_pipe_array #(.DATA_WIDTH(DW), .LANES(LN), .Q(8380417), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mode_i(mode), .half_i(half), .tag_i(tag_in), .a_i(a_in), .b_i(b_in), .zeta_i(z_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .tag_o(tag_out),
    .a_o(a_out), .b_o(b_out), .busy_o(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic mode;
    logic half;
    logic [TW-1:0] tag;
    logic [LN*DW-1:0] a, b, z, ea, eb;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic m, input logic h, input logic [TW-1:0] t,
                              input logic [31:0] a0, b0, z0, a1, b1, z1,
                              input logic [31:0] ea0, eb0, ea1, eb1);
    vec_t v;
    v.mode = m; v.half = h; v.tag = t;
    v.a = {a1, a0}; v.b = {b1, b0}; v.z = {z1, z0};
    v.ea = {ea1, ea0}; v.eb = {eb1, eb0};
    return v;
  endfunction

  function automatic logic [63:0] model_lane(input logic m, input logic h,
                                             input longint unsigned a, b, z);
    longint unsigned ra, rb, t;
    if (!m) begin
      t  = (z * b) % QQ;
      ra = (a + t) % QQ;
      rb = (a + QQ - t) % QQ;
    end else begin
      ra = (a + b) % QQ;
      rb = (((a + QQ - b) % QQ) * z) % QQ;
    end
    if (h) begin
      ra = ra[0] ? (ra + QQ) / 2 : ra / 2;
      rb = rb[0] ? (rb + QQ) / 2 : rb / 2;
    end
    return {32'(ra), 32'(rb)};
  endfunction

  function automatic logic [2*LN*DW-1:0] model_beat(input logic m, input logic h,
                                                    input logic [LN*DW-1:0] a, b, z);
    logic [LN*DW-1:0] ea, eb;
    logic [63:0] r;
    for (int k = 0; k < LN; k++) begin
      r = model_lane(m, h, 64'(a[k*DW +: DW]), 64'(b[k*DW +: DW]), 64'(z[k*DW +: DW]));
      ea[k*DW +: DW] = r[63:32];
      eb[k*DW +: DW] = r[31:0];
    end
    return {ea, eb};
  endfunction

  task automatic drive_vec(input vec_t v);
    in_valid = 1'b1; mode = v.mode; half = v.half; tag_in = v.tag;
    a_in = v.a; b_in = v.b; z_in = v.z;
  endtask

  task automatic apply_one(input vec_t v, input string name);
    int lat;
    out_ready = 1'b1;
    drive_vec(v);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 160'(lat), 160'(3));
    check({name, "_a"}, 160'(a_out), 160'(v.ea));
    check({name, "_b"}, 160'(b_out), 160'(v.eb));
    check({name, "_tag"}, 160'(tag_out), 160'(v.tag));
    tick();
  endtask

  task automatic run_stream(input int n, input bit rnd, input string name);
    logic [TW+2*LN*DW-1:0] expq[$];
    logic [TW+2*LN*DW-1:0] held, exp_v;
    logic m, h;
    logic [LN*DW-1:0] a, b, z;
    int sent = 0, got = 0, cyc = 0;
    bit pending = 0, stalled_prev = 0;
    while (got < n && cyc < n * 8 + 50) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : (cyc % 4 == 0 || cyc % 4 == 3);
      if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        if (!pending) begin
          m = 1'($urandom_range(0, 1));
          h = 1'($urandom_range(0, 1));
          for (int k = 0; k < LN; k++) begin
            a[k*DW +: DW] = ($urandom_range(0, 7) == 0) ? QM1 : $urandom_range(0, 32'(QQ - 1));
            b[k*DW +: DW] = ($urandom_range(0, 7) == 0) ? QM1 : $urandom_range(0, 32'(QQ - 1));
            z[k*DW +: DW] = ($urandom_range(0, 7) == 0) ? QM1 : $urandom_range(0, 32'(QQ - 1));
          end
          pending = 1;
        end
        in_valid = 1'b1; mode = m; half = h; tag_in = TW'(sent);
        a_in = a; b_in = b; z_in = z;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check({name, "_in_ready"}, 160'(in_ready), 160'(!out_valid || out_ready));
      if (stalled_prev)
        check({name, "_hold"}, 160'({tag_out, a_out, b_out}), 160'(held));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check({name, "_spurious"}, 160'(1), 160'(0));
        end else begin
          exp_v = expq.pop_front();
          check({name, "_beat"}, 160'({tag_out, a_out, b_out}), 160'(exp_v));
        end
        got++;
      end
      stalled_prev = out_valid && !out_ready;
      held = {tag_out, a_out, b_out};
      if (in_valid && in_ready) begin
        expq.push_back({TW'(sent), model_beat(m, h, a, b, z)});
        sent++;
        pending = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({name, "_count"}, 160'(got), 160'(n));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check({name, "_drained"}, 160'({busy, out_valid}), 160'(0));
  endtask

  initial begin
    bit saw_out;
    vecs[0] = mk(1'b0, 1'b0, 8'h11, 5, 3, 2, 0, 1, 1, 11, QM1, 1, QM1);
    vecs[1] = mk(1'b1, 1'b0, 8'h22, 5, 3, 2, 1, 3, 1, 8, 4, 4, QM2);
    vecs[2] = mk(1'b1, 1'b1, 8'h33, 5, 3, 2, 4, 3, 1, 4, 2, 4190212, 4190209);
    vecs[3] = mk(1'b0, 1'b0, 8'h44, QM1, QM1, QM1, QM1, 2, QM1, 0, QM2, QM3, 1);
    vecs[4] = mk(1'b1, 1'b0, 8'h55, QM1, QM1, QM1, QM1, 1, QM1, QM2, 0, 0, 2);
    vecs[5] = mk(1'b0, 1'b1, 8'h66, 5, 3, 2, 0, 0, 0, 4190214, 4190208, 0, 0);
    vecs[6] = mk(1'b0, 1'b0, 8'h77, 0, 1000, 1753, QM1, 0, 5, 1753000, 6627417, QM1, QM1);

    // Reset held for two edges with a beat presented: it must never emerge.
    reset_ni = 1'b0;
    drive_vec(vecs[0]);
    tick();
    tick();
    reset_ni = 1'b1;
    in_valid = 1'b0;
    check("rst_out_valid", 160'(out_valid), 160'(0));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_in_ready", 160'(in_ready), 160'(1));
    check("rst_outputs", 160'({tag_out, a_out, b_out}), 160'(0));
    saw_out = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) saw_out = 1;
    end
    check("rst_no_output", 160'(saw_out), 160'(0));

    foreach (vecs[i]) apply_one(vecs[i], $sformatf("vec%0d", i));

    // Mixed modes back-to-back with no gaps.
    run_stream(10, 1'b0, "bp");

    // Three beats in flight, then reset.
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_vec(vecs[i]);
      tick();
    end
    in_valid = 1'b0;
    check("mid_busy", 160'(busy), 160'(1));
    reset_ni = 1'b0;
    tick();
    check("mid_rst_out_valid", 160'(out_valid), 160'(0));
    check("mid_rst_busy", 160'(busy), 160'(0));
    reset_ni = 1'b1;
    apply_one(vecs[6], "post_rst");

    run_stream(10000, 1'b1, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
